// File: rtl/dmem_pkg.sv
// Shared types and helpers for the dmem_responder data-memory slice.
// Size encoding, FSM state encoding, wait counter width and the
// alignment helpers used by the top level.
package dmem_pkg;

  localparam int WAIT_CW = 4;

  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_HALF = 2'b01,
    SZ_BYTE = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  // Clear the low address bits that a half/word access cannot use.
  function automatic logic [1:0] align_lo(input logic [1:0] sz, input logic [1:0] lo);
    case (sz)
      SZ_HALF: return {lo[1], 1'b0};
      SZ_BYTE: return lo;
      default: return 2'b00;
    endcase
  endfunction

  // True when the low address bits do not fit the access size.
  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] lo);
    case (sz)
      SZ_HALF: return lo[0];
      SZ_BYTE: return 1'b0;
      default: return (lo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/dmem_bytelane.sv
// Byte-lane steering for dmem_responder: write strobes and lane-replicated
// write data for stores, right-aligned zero-extended data for loads.
module dmem_bytelane
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wlane,
  output logic [31:0] rdata
);

  // Decode strobes and align data from access size and byte offset.
  always_comb begin
    be    = 4'b1111;
    wlane = wdata;
    rdata = rword;
    case (size)
      SZ_HALF: begin
        be    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wlane = {2{wdata[15:0]}};
        rdata = {16'h0000, (addr_lo[1] ? rword[31:16] : rword[15:0])};
      end
      SZ_BYTE: begin
        be    = 4'b0001 << addr_lo;
        wlane = {4{wdata[7:0]}};
        case (addr_lo)
          2'd0:    rdata = {24'h0, rword[7:0]};
          2'd1:    rdata = {24'h0, rword[15:8]};
          2'd2:    rdata = {24'h0, rword[23:16]};
          default: rdata = {24'h0, rword[31:24]};
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder with a fixed number of wait states.
// Optional macro DMEM_MISALIGN_TRAP_EN: misaligned half/word accesses
// complete with err=1 and no side effect instead of being force-aligned.
//
// state   | meaning
// IDLE    | waiting for memread/memwrite, latches the request
// WAIT    | counting down wait states on the latched request
// RESP    | one-cycle ready pulse, readdata valid
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int WAIT  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        ready,
  output logic        stall,
  output logic        err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e               state_q, state_d;
  logic [WAIT_CW-1:0]   cnt_q, cnt_d;
  logic [31:0]          addr_q, wdata_q, readdata_q;
  logic [1:0]           size_q;
  logic                 store_q;
  logic                 latch_en, enter_resp;

  logic                 acc_live, acc_store, acc_mis, do_write;
  logic [31:0]          acc_addr, acc_wdata, load_val;
  logic [1:0]           acc_size, lane_lo;
  logic [AW-1:0]        idx;
  logic [3:0]           be;
  logic [31:0]          wlane, lane_rdata, mem_word;
  logic [31:0]          mem [DEPTH];
  logic                 unused_addr_hi;

  // Next-state logic; WAIT=0 skips straight to RESP.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    latch_en   = 1'b0;
    enter_resp = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (memread | memwrite) begin
          latch_en = 1'b1;
          if (WAIT == 0) begin
            state_d    = ST_RESP;
            enter_resp = 1'b1;
            cnt_d      = '0;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_CW'(WAIT);
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q <= WAIT_CW'(1)) begin
          state_d    = ST_RESP;
          enter_resp = 1'b1;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q - WAIT_CW'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counter and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      readdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (enter_resp) readdata_q <= load_val;
    end
  end

  // Capture the request on acceptance; later input changes are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= SZ_WORD;
      store_q <= 1'b0;
    end else if (latch_en) begin
      addr_q  <= addr;
      wdata_q <= writedata;
      size_q  <= size;
      store_q <= memwrite;
    end
  end

  // In IDLE the live inputs are used so WAIT=0 can respond without latching first.
  always_comb begin
    acc_live  = (state_q == ST_IDLE);
    acc_addr  = acc_live ? addr      : addr_q;
    acc_wdata = acc_live ? writedata : wdata_q;
    acc_size  = acc_live ? size      : size_q;
    acc_store = acc_live ? memwrite  : store_q;
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  logic err_q;

  assign acc_mis = misaligned(acc_size, acc_addr[1:0]);
  assign lane_lo = acc_addr[1:0];

  // Misalignment flag captured alongside the response data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           err_q <= 1'b0;
    else if (enter_resp) err_q <= acc_mis;
  end

  assign err = err_q & ready;
`else
  assign acc_mis = 1'b0;
  assign lane_lo = align_lo(acc_size, acc_addr[1:0]);
  assign err     = 1'b0;
`endif

  assign idx            = acc_addr[AW+1:2];
  assign unused_addr_hi = ^acc_addr[31:AW+2];
  assign mem_word       = mem[idx];

  dmem_bytelane u_bytelane (
    .size    (acc_size),
    .addr_lo (lane_lo),
    .wdata   (acc_wdata),
    .rword   (mem_word),
    .be      (be),
    .wlane   (wlane),
    .rdata   (lane_rdata)
  );

  assign load_val = (acc_store | acc_mis) ? 32'h0 : lane_rdata;
  assign do_write = enter_resp & acc_store & ~acc_mis & ~reset;

  // Data store, not reset; only the strobed lanes change on RESP entry.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

  assign ready    = (state_q == ST_RESP);
  assign readdata = readdata_q;
  assign stall    = (memread | memwrite) & ~ready;

endmodule
